// File: rtl/demux8_pkg.sv
// demux8_pkg: shared slot-counter constants and slot sequencing helpers
package demux8_pkg;
  localparam int SLOT_W = 3;
  localparam int NUM_SLOTS = 8;
  function automatic logic [SLOT_W-1:0] start_slot(input logic lsb_first);
    return lsb_first ? '0 : SLOT_W'(NUM_SLOTS - 1);
  endfunction
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot, input logic lsb_first);
    return lsb_first ? slot + 1'b1 : slot - 1'b1;
  endfunction
endpackage

// File: rtl/demux8_slot_ctr.sv
// demux8_slot_ctr: demux select counter with sof reload, byte-wrap and pending-bit flags
module demux8_slot_ctr
  import demux8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              sof,
  output logic [SLOT_W-1:0] slot,
  output logic [SLOT_W-1:0] wr_idx,
  output logic              wrap,
  output logic              pending
);
  localparam logic [SLOT_W-1:0] START = start_slot(LSB_FIRST);
  logic [SLOT_W-1:0] slot_q, slot_d;
  assign slot    = slot_q;
  assign wr_idx  = sof ? START : slot_q;
  assign pending = slot_q != START;
  // a byte completes when the slot just written is the last before the start slot
  assign wrap    = accept & (next_slot(wr_idx, LSB_FIRST) == START);
  always_comb begin
    slot_d = accept ? next_slot(wr_idx, LSB_FIRST) : slot_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= START;
    else       slot_q <= slot_d;
  end
endmodule

// File: rtl/demux8_deser.sv
// demux8_deser: bit-serial to byte deserializer with two-deep byte buffering and valid/ready handshakes
module demux8_deser
  import demux8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              sof,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_err
);
  logic [7:0]        asm_q, asm_d, byte_out_q, byte_out_d, merged;
  logic              asm_full_q, asm_full_d, byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
  logic              accept, drain, wrap, pending, load_out;
  logic [SLOT_W-1:0] wr_idx;
  assign bit_ready  = !asm_full_q;
  assign accept     = bit_valid & bit_ready;
  assign drain      = byte_valid_q & byte_ready;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  demux8_slot_ctr #(.LSB_FIRST(LSB_FIRST)) u_ctr (
    .clk(clk), .reset(reset), .accept(accept), .sof(sof),
    .slot(slot), .wr_idx(wr_idx), .wrap(wrap), .pending(pending)
  );
  // sof restarts assembly from an empty register, dropping any partial byte
  always_comb begin
    merged         = sof ? '0 : asm_q;
    merged[wr_idx] = bit_in;
    load_out       = accept & wrap & (!byte_valid_q | byte_ready);
    byte_out_d     = load_out ? merged : (drain & asm_full_q) ? asm_q : byte_out_q;
    byte_valid_d   = load_out | (drain ? asm_full_q : byte_valid_q);
    asm_full_d     = (accept & wrap & !load_out) | (asm_full_q & !drain);
    asm_d          = (load_out | (drain & asm_full_q)) ? '0 : accept ? merged : asm_q;
    frame_err_d    = accept & sof & pending;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q        <= '0;
      asm_full_q   <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      asm_full_q   <= asm_full_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_demux8_deser.sv
// tb_demux8_deser: directed-vector bench for LSB-first and MSB-first deserializers
module tb_demux8_deser;
  logic       clk = 1'b0, reset = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, sof = 1'b0, byte_ready = 1'b0;
  logic       bit_ready, byte_valid, frame_err, bit_ready_m, byte_valid_m, frame_err_m;
  logic [7:0] byte_out, byte_out_m;
  logic [2:0] slot, slot_m;
  int         n = 0, errs = 0;

  always #5 clk = ~clk;

  demux8_deser #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sof(sof), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .slot(slot), .frame_err(frame_err)
  );
  demux8_deser #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_m),
    .sof(sof), .byte_out(byte_out_m), .byte_valid(byte_valid_m), .byte_ready(byte_ready),
    .slot(slot_m), .frame_err(frame_err_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic s);
    bit_in = b; sof = s; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    for (int i = 0; i < 8; i++) send(b[i], s && i == 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_slot"}, 32'(slot), 0);
    chk({tag, "_slot_m"}, 32'(slot_m), 7);
    chk({tag, "_bit_ready"}, 32'(bit_ready), 1);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 0);
    chk({tag, "_byte_out"}, 32'(byte_out), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk_reset("t1_rst");
    // T1/T2: alternating stream, both bit orders
    byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t1_slot", 32'(slot), 32'(i));
      chk("t2_slot_m", 32'(slot_m), 32'(7 - i));
      if (i == 7) chk("t1_valid_early", 32'(byte_valid), 0);
      send(i[0], i == 0);
    end
    chk("t1_valid", 32'(byte_valid), 1);
    chk("t1_byte", 32'(byte_out), 32'h AA);
    chk("t2_byte_m", 32'(byte_out_m), 32'h55);
    chk("t1_slot_wrap", 32'(slot), 0);
    chk("t2_slot_m_wrap", 32'(slot_m), 7);
    tick();
    chk("t1_drained", 32'(byte_valid), 0);
    // T3: back-pressure, two bytes buffered
    byte_ready = 1'b0;
    send_byte(8'hFF, 1'b1);
    chk("t3_first_valid", 32'(byte_valid), 1);
    chk("t3_first_byte", 32'(byte_out), 32'hFF);
    chk("t3_ready_mid", 32'(bit_ready), 1);
    send_byte(8'h00, 1'b0);
    chk("t3_ready_full", 32'(bit_ready), 0);
    chk("t3_hold", 32'(byte_out), 32'hFF);
    send(1'b1, 1'b0);
    chk("t3_hold2", 32'(byte_out), 32'hFF);
    chk("t3_slot_blocked", 32'(slot), 0);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    chk("t3_second_byte", 32'(byte_out), 32'h00);
    chk("t3_second_valid", 32'(byte_valid), 1);
    chk("t3_ready_back", 32'(bit_ready), 1);
    byte_ready = 1'b1;
    tick();
    chk("t3_drained", 32'(byte_valid), 0);
    // T4: sof with partial byte pending
    send(1'b0, 1'b1);
    chk("t4_no_err_aligned", 32'(frame_err), 0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("t4_slot3", 32'(slot), 3);
    send(1'b1, 1'b1);
    chk("t4_err", 32'(frame_err), 1);
    chk("t4_slot1", 32'(slot), 1);
    tick();
    chk("t4_err_once", 32'(frame_err), 0);
    for (int i = 1; i < 8; i++) send(i == 7, 1'b0);
    chk("t4_byte", 32'(byte_out), 32'h81);
    chk("t4_valid", 32'(byte_valid), 1);
    tick();
    // T5: sparse bit_valid
    for (int i = 0; i < 8; i++) begin
      send(((8'h3C >> i) & 8'h01) != 0, i == 0);
      tick();
      tick();
      chk("t5_slot_idle", 32'(slot), 32'((i + 1) % 8));
    end
    chk("t5_byte", 32'(byte_out), 32'h3C);
    tick();
    // T6: async reset mid-byte and with both buffers full
    send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset("t6_rst_mid");
    tick();
    reset = 1'b0;
    byte_ready = 1'b0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b0);
    chk("t6_full", 32'(bit_ready), 0);
    reset = 1'b1;
    #1;
    chk_reset("t6_rst_full");
    tick();
    reset = 1'b0;
    byte_ready = 1'b1;
    send_byte(8'h0F, 1'b0);
    chk("t6_clean_byte", 32'(byte_out), 32'h0F);
    chk("t6_clean_valid", 32'(byte_valid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
